// File: rtl/regfile_sequencer.sv
// regfile_sequencer: command-side initiator for the 16-bit register file.
// Accepts one ALU/move command per handshake, reads both operands through the
// register file's combinational read ports, computes the result and issues a
// single write-back through the shared write address (rf_register1).
// Optional build macro REGSEQ_OVERLAP_EN: accept the next command during WB,
// raising throughput from one command per 4 cycles to one per 3 cycles.
module regfile_sequencer #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int MAX_REG = 10,
    parameter int CMP_REG = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rdest,
    input  logic [ADDR_W-1:0] cmd_rsrc,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] rf_register1,
    output logic [ADDR_W-1:0] rf_register2,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              rf_write,
    input  logic [DATA_W-1:0] rf_r1_data,
    input  logic [DATA_W-1:0] rf_r2_data,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result
);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_MOV  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_MOVI = 4'd7;
    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_CMP  = 4'd9;
    localparam logic [3:0] OP_LSH  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t              state_reg;
    state_t              state_next;

    logic [3:0]          op_reg;
    logic [ADDR_W-1:0]   rdest_reg;
    logic [ADDR_W-1:0]   rsrc_reg;
    logic [DATA_W-1:0]   imm_reg;
    logic [DATA_W-1:0]   opa_reg;
    logic [DATA_W-1:0]   opb_reg;
    logic [DATA_W-1:0]   result_reg;
    logic [ADDR_W-1:0]   waddr_reg;
    logic                wen_reg;
    logic                err_reg;

    logic                ready_int;
    logic                accept;
    logic [DATA_W-1:0]   alu_next;
    logic                err_next;
    logic                wen_next;
    logic [ADDR_W-1:0]   waddr_next;

    logic [ADDR_W-1:0]   field [2];
    logic [1:0]          field_ok;
    logic                op_legal;
    logic                uses_rdest;
    logic                uses_rsrc;

    // Acceptance window: IDLE always, WB as well when overlapping is built in.
`ifdef REGSEQ_OVERLAP_EN
    assign ready_int = (state_reg == S_IDLE) || (state_reg == S_WB);
`else
    assign ready_int = (state_reg == S_IDLE);
`endif

    // Reset masks the handshake so nothing is captured while reset is high.
    assign cmd_ready = ready_int && !reset;
    assign accept    = cmd_valid && cmd_ready;

    // Register-field legality: a field is usable when it is 1..MAX_REG.
    assign field[0] = rdest_reg;
    assign field[1] = rsrc_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_field_chk
            assign field_ok[gi] = (field[gi] != '0) &&
                                  (field[gi] <= ADDR_W'(MAX_REG));
        end
    endgenerate

    // Decode which fields the captured opcode depends on and whether it exists.
    always_comb begin
        op_legal   = (op_reg <= OP_LSH);
        uses_rdest = (op_reg != OP_NOP);
        uses_rsrc  = 1'b0;
        case (op_reg)
            OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_CMP, OP_LSH: uses_rsrc = 1'b1;
            default:        uses_rsrc = 1'b0;
        endcase
    end

    // Error, write-enable and write-address decisions made in EXEC.
    always_comb begin
        err_next   = !op_legal ||
                     (uses_rdest && !field_ok[0]) ||
                     (uses_rsrc  && !field_ok[1]);
        wen_next   = !err_next && (op_reg != OP_NOP);
        waddr_next = (op_reg == OP_CMP) ? ADDR_W'(CMP_REG) : rdest_reg;
    end

    // Datapath: all arithmetic wraps at DATA_W bits.
    always_comb begin
        alu_next = '0;
        case (op_reg)
            OP_MOV:  alu_next = opb_reg;
            OP_ADD:  alu_next = opa_reg + opb_reg;
            OP_SUB:  alu_next = opa_reg - opb_reg;
            OP_AND:  alu_next = opa_reg & opb_reg;
            OP_OR:   alu_next = opa_reg | opb_reg;
            OP_XOR:  alu_next = opa_reg ^ opb_reg;
            OP_MOVI: alu_next = imm_reg;
            OP_ADDI: alu_next = opa_reg + imm_reg;
            OP_CMP: begin
                alu_next[0] = (opa_reg == opb_reg);
                alu_next[1] = (opa_reg < opb_reg);
                alu_next[2] = ($signed(opa_reg) < $signed(opb_reg));
            end
            OP_LSH:  alu_next = opa_reg << opb_reg[3:0];
            default: alu_next = '0;
        endcase
    end

    // Next-state logic for the IDLE -> READ -> EXEC -> WB loop.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = S_READ;
            S_READ: state_next = S_EXEC;
            S_EXEC: state_next = S_WB;
            S_WB:   state_next = accept ? S_READ : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register; reset aborts any command in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Command capture, operand latch and EXEC results.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg     <= '0;
            rdest_reg  <= '0;
            rsrc_reg   <= '0;
            imm_reg    <= '0;
            opa_reg    <= '0;
            opb_reg    <= '0;
            result_reg <= '0;
            waddr_reg  <= '0;
            wen_reg    <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            if (accept) begin
                op_reg    <= cmd_op;
                rdest_reg <= cmd_rdest;
                rsrc_reg  <= cmd_rsrc;
                imm_reg   <= cmd_imm;
            end
            if (state_reg == S_READ) begin
                opa_reg <= rf_r1_data;
                opb_reg <= rf_r2_data;
            end
            if (state_reg == S_EXEC) begin
                result_reg <= alu_next;
                waddr_reg  <= waddr_next;
                wen_reg    <= wen_next;
                err_reg    <= err_next;
            end
        end
    end

    // Register-file port drive and completion pulses; all quiet while in reset.
    always_comb begin
        rf_register1 = '0;
        rf_register2 = '0;
        rf_data_in   = '0;
        rf_write     = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (state_reg)
            S_READ: begin
                rf_register1 = rdest_reg;
                rf_register2 = rsrc_reg;
            end
            S_WB: begin
                rf_register1 = waddr_reg;
                rf_data_in   = result_reg;
                rf_write     = wen_reg && !reset;
                done         = !reset;
                err          = err_reg && !reset;
            end
            default: ;
        endcase
    end

    assign result = result_reg;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Testbench for regfile_sequencer: behavioural register file, table-driven
// single-command vectors with a scoreboard queue, plus reset-abort and
// back-to-back sequences.
module tb_regfile_sequencer;

    localparam int DW = 16;
    localparam int AW = 5;
`ifdef REGSEQ_OVERLAP_EN
    localparam int SPACING = 3;
`else
    localparam int SPACING = 4;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [AW-1:0] cmd_rdest;
    logic [AW-1:0] cmd_rsrc;
    logic [DW-1:0] cmd_imm;
    logic [AW-1:0] rf_register1;
    logic [AW-1:0] rf_register2;
    logic [DW-1:0] rf_data_in;
    logic          rf_write;
    logic [DW-1:0] rf_r1_data;
    logic [DW-1:0] rf_r2_data;
    logic          done;
    logic          err;
    logic [DW-1:0] result;

    regfile_sequencer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rdest(cmd_rdest), .cmd_rsrc(cmd_rsrc), .cmd_imm(cmd_imm),
        .rf_register1(rf_register1), .rf_register2(rf_register2),
        .rf_data_in(rf_data_in), .rf_write(rf_write),
        .rf_r1_data(rf_r1_data), .rf_r2_data(rf_r2_data),
        .done(done), .err(err), .result(result)
    );

    always #5 clk = ~clk;

    // Behavioural register file: combinational reads, write on rising edge.
    logic [DW-1:0] rf_mem [0:31] = '{default: '0};
    int            wr_count = 0;
    int            cyc = 0;

    assign rf_r1_data = rf_mem[rf_register1];
    assign rf_r2_data = rf_mem[rf_register2];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_write) begin
            rf_mem[rf_register1] <= rf_data_in;
            wr_count <= wr_count + 1;
        end
    end

    typedef struct {
        logic [3:0]    op;
        logic [AW-1:0] rd;
        logic [AW-1:0] rs;
        logic [DW-1:0] imm;
        logic          e_err;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
    } vec_t;

    typedef struct {
        logic          e_err;
        logic          e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_data;
    } exp_t;

    vec_t vecs[$];
    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [3:0] op, input logic [AW-1:0] rd, input logic [AW-1:0] rs,
                                input logic [DW-1:0] imm, input logic e_err, input logic e_wr,
                                input logic [AW-1:0] e_addr, input logic [DW-1:0] e_data);
        vec_t v;
        v.op = op; v.rd = rd; v.rs = rs; v.imm = imm;
        v.e_err = e_err; v.e_wr = e_wr; v.e_addr = e_addr; v.e_data = e_data;
        vecs.push_back(v);
    endfunction

    task automatic drive(input vec_t v);
        cmd_op    = v.op;
        cmd_rdest = v.rd;
        cmd_rsrc  = v.rs;
        cmd_imm   = v.imm;
    endtask

    function automatic exp_t to_exp(input vec_t v);
        exp_t e;
        e.e_err = v.e_err; e.e_wr = v.e_wr; e.e_addr = v.e_addr; e.e_data = v.e_data;
        return e;
    endfunction

    // One command: handshake, push expectation, wait for done, pop and compare.
    task automatic run_cmd(input vec_t v, input int idx);
        int   w;
        int   lat;
        int   wc0;
        exp_t e;
        @(negedge clk);
        drive(v);
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            check($sformatf("v%0d handshake timeout", idx), 32'd0, 32'd1);
            cmd_valid = 1'b0;
            return;
        end
        wc0 = wr_count;
        sbq.push_back(to_exp(v));
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (!done && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("v%0d latency", idx), lat, 3);
        if (done && sbq.size() > 0) begin
            e = sbq.pop_front();
            check($sformatf("v%0d err", idx), {31'd0, err}, {31'd0, e.e_err});
            check($sformatf("v%0d rf_write", idx), {31'd0, rf_write}, {31'd0, e.e_wr});
            if (e.e_wr) begin
                check($sformatf("v%0d waddr", idx), {27'd0, rf_register1}, {27'd0, e.e_addr});
                check($sformatf("v%0d wdata", idx), {16'd0, rf_data_in}, {16'd0, e.e_data});
            end
            @(negedge clk);
            check($sformatf("v%0d done pulse", idx), {31'd0, done}, 32'd0);
            check($sformatf("v%0d ready after", idx), {31'd0, cmd_ready}, 32'd1);
            check($sformatf("v%0d write count", idx), wr_count - wc0, e.e_wr ? 32'd1 : 32'd0);
            if (e.e_wr) begin
                check($sformatf("v%0d rf[%0d]", idx, e.e_addr), {16'd0, rf_mem[e.e_addr]}, {16'd0, e.e_data});
                check($sformatf("v%0d result", idx), {16'd0, result}, {16'd0, e.e_data});
            end
            $display("[TB] cmd %0d op=%0d rd=%0d rs=%0d imm=0x%04h err=%0d wr=%0d data=0x%04h",
                     idx, v.op, v.rd, v.rs, v.imm, e.e_err, e.e_wr, e.e_data);
        end
    endtask

    initial begin
        int   wc0;
        int   hs;
        int   nd;
        int   dt [2];
        bit   pend;
        vec_t b2b [2];
        exp_t e;

        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = '0; cmd_rdest = '0; cmd_rsrc = '0; cmd_imm = '0;

        //   op  rd  rs  imm      err wr addr data
        add(7,  1,  0, 16'h1234, 0, 1, 1,  16'h1234);
        add(7,  1,  0, 16'hFFFF, 0, 1, 1,  16'hFFFF);
        add(7,  2,  0, 16'h0002, 0, 1, 2,  16'h0002);
        add(2,  1,  2, 16'h0000, 0, 1, 1,  16'h0001);
        add(3,  2,  1, 16'h0000, 0, 1, 2,  16'h0001);
        add(7,  3,  0, 16'h8000, 0, 1, 3,  16'h8000);
        add(7,  4,  0, 16'h0001, 0, 1, 4,  16'h0001);
        add(9,  3,  4, 16'h0000, 0, 1, 9,  16'h0004);
        add(1,  3,  4, 16'h0000, 0, 1, 3,  16'h0001);
        add(9,  3,  4, 16'h0000, 0, 1, 9,  16'h0001);
        add(2,  0,  2, 16'h0000, 1, 0, 0,  16'h0000);
        add(12, 1,  2, 16'h0000, 1, 0, 0,  16'h0000);
        add(7,  5,  0, 16'hF0F0, 0, 1, 5,  16'hF0F0);
        add(7,  6,  0, 16'h3C3C, 0, 1, 6,  16'h3C3C);
        add(4,  5,  6, 16'h0000, 0, 1, 5,  16'h3030);
        add(5,  6,  5, 16'h0000, 0, 1, 6,  16'h3C3C);
        add(6,  6,  5, 16'h0000, 0, 1, 6,  16'h0C0C);
        add(7,  7,  0, 16'h0003, 0, 1, 7,  16'h0003);
        add(7,  8,  0, 16'h0011, 0, 1, 8,  16'h0011);
        add(10, 7,  8, 16'h0000, 0, 1, 7,  16'h0006);
        add(8,  7,  0, 16'hFFFF, 0, 1, 7,  16'h0005);
        add(7,  10, 0, 16'hBEEF, 0, 1, 10, 16'hBEEF);
        add(0,  0,  0, 16'h0000, 0, 0, 0,  16'h0000);
        add(7,  11, 0, 16'h1111, 1, 0, 0,  16'h0000);
        add(1,  1,  0, 16'h0000, 1, 0, 0,  16'h0000);
        add(1,  1,  11, 16'h0000, 1, 0, 0, 16'h0000);
        add(7,  1,  0, 16'h0042, 0, 1, 1,  16'h0042);
        add(7,  5,  0, 16'h5555, 0, 1, 5,  16'h5555);

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready in reset", {31'd0, cmd_ready}, 32'd0);
        check("write in reset", {31'd0, rf_write}, 32'd0);
        reset = 1'b0;
        #1;
        check("reset ready", {31'd0, cmd_ready}, 32'd1);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        check("reset reg1", {27'd0, rf_register1}, 32'd0);
        check("reset reg2", {27'd0, rf_register2}, 32'd0);
        check("reset data_in", {16'd0, rf_data_in}, 32'd0);
        check("reset result", {16'd0, result}, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_cmd(vecs[i], i);
        end

        // Reset during EXEC of MOVI R5=0xAAAA aborts it.
        @(negedge clk);
        cmd_op = 4'd7; cmd_rdest = 5'd5; cmd_rsrc = 5'd0; cmd_imm = 16'hAAAA;
        cmd_valid = 1'b1;
        wc0 = wr_count;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("abort in read", {27'd0, rf_register1}, 32'd5);
        @(negedge clk);
        reset = 1'b1;
        check("abort write in reset", {31'd0, rf_write}, 32'd0);
        check("abort done in reset", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort ready after reset", {31'd0, cmd_ready}, 32'd1);
        check("abort done after reset", {31'd0, done}, 32'd0);
        repeat (4) @(negedge clk);
        check("abort no write", wr_count - wc0, 32'd0);
        check("abort R5 kept", {16'd0, rf_mem[5]}, 32'h5555);
        $display("[TB] abort MOVI R5 R5=0x%04h writes=%0d", rf_mem[5], wr_count - wc0);

        // Back-to-back with cmd_valid held: MOVI R1=7 then ADDI R1+1.
        b2b[0].op = 4'd7; b2b[0].rd = 5'd1; b2b[0].rs = 5'd0; b2b[0].imm = 16'd7;
        b2b[0].e_err = 0; b2b[0].e_wr = 1; b2b[0].e_addr = 5'd1; b2b[0].e_data = 16'd7;
        b2b[1].op = 4'd8; b2b[1].rd = 5'd1; b2b[1].rs = 5'd0; b2b[1].imm = 16'd1;
        b2b[1].e_err = 0; b2b[1].e_wr = 1; b2b[1].e_addr = 5'd1; b2b[1].e_data = 16'd8;
        hs = 0; nd = 0; pend = 1'b0; dt[0] = 0; dt[1] = 0;
        @(negedge clk);
        drive(b2b[0]);
        cmd_valid = 1'b1;
        for (int t = 0; t < 40 && nd < 2; t++) begin
            if (done) begin
                if (nd < 2) dt[nd] = cyc;
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    check($sformatf("b2b%0d wdata", nd), {16'd0, rf_data_in}, {16'd0, e.e_data});
                    check($sformatf("b2b%0d write", nd), {31'd0, rf_write}, 32'd1);
                end
                $display("[TB] b2b done %0d at cycle %0d data=0x%04h", nd, cyc, rf_data_in);
                nd++;
            end
            if (pend) begin
                hs++;
                if (hs < 2) drive(b2b[hs]);
                else cmd_valid = 1'b0;
            end
            pend = cmd_valid && cmd_ready;
            if (pend) sbq.push_back(to_exp(b2b[hs]));
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("b2b done count", nd, 2);
        check("b2b spacing", dt[1] - dt[0], SPACING);
        check("b2b R1 final", {16'd0, rf_mem[1]}, 32'h0008);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global guard so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL global timeout: got hang expected finish");
        $fatal(1);
    end

endmodule
